// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared types for the pipeline trace buffer.
// State codes, mode codes and the record qualifier.
package pipeline_trace_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_POST = 3'd2,
        ST_DONE = 3'd3
    } trace_state_e;

    localparam logic [1:0] MODE_WRAP_TRIG = 2'd0;
    localparam logic [1:0] MODE_STOP_FULL = 2'd1;

    function automatic logic is_record(
        input logic valid,
        input logic filter_x0,
        input logic dest_zero
    );
        return valid & ~(filter_x0 & dest_zero);
    endfunction

endpackage

// File: rtl/pipeline_trace_buffer_if.sv
// Writeback tap and readout stream of the trace buffer.
// master drives writebacks and consumes entries; slave is the buffer.
interface pipeline_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_W  = 5
);
    logic                      wb_valid;
    logic [REG_W-1:0]          wb_dest;
    logic [DATA_W-1:0]         wb_value;
    logic [PC_W-1:0]           wb_pc;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [PC_W+REG_W+DATA_W-1:0] rd_data;
    logic                      rd_last;

    modport master (
        output wb_valid, wb_dest, wb_value, wb_pc,
        output rd_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  wb_valid, wb_dest, wb_value, wb_pc,
        input  rd_ready,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/pipeline_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port.
// No reset; contents are only read after being written.
module trace_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 69,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // write port
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port
    always_ff @(posedge clock) begin
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pipeline_trace_buffer.sv
// Writeback trace capture with trigger and oldest-first readout.
// FSM, pointers, post counter, and a two-deep output stage fed by the RAM.
module pipeline_trace_buffer
    import pipeline_trace_buffer_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int DATA_W    = 32,
    parameter  int PC_W      = 32,
    parameter  int REG_W     = 5,
    parameter  bit FILTER_X0 = 1'b1,
    localparam int AW        = $clog2(DEPTH),
    localparam int EW        = PC_W + REG_W + DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic                 trig_en,
    input  logic [PC_W-1:0]      trig_pc,
    input  logic [AW-1:0]        post_count,
    pipeline_trace_buffer_if.slave bus,
    output logic [2:0]           state,
    output logic [AW:0]          count,
    output logic                 overflow
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   fetch_q, fetch_d;
    logic [AW-1:0] post_q, post_d;
    logic          overflow_q, overflow_d;
    logic          inflight_q, inflight_d;
    logic          out_v_q, out_v_d;
    logic [EW-1:0] out_data_q, out_data_d;
    logic          skid_v_q, skid_v_d;
    logic [EW-1:0] skid_data_q, skid_data_d;

    logic          rec, stop_full, trig_hit, pop;
    logic          ram_we, ram_re;
    logic [EW-1:0] ram_rdata;
    logic [1:0]    occ;

    assign rec       = is_record(bus.wb_valid, FILTER_X0,
                                 bus.wb_dest == '0);
    assign stop_full = (mode == MODE_STOP_FULL);
    assign trig_hit  = trig_en && (bus.wb_pc == trig_pc);
    assign pop       = out_v_q & bus.rd_ready;
    assign occ       = {1'b0, out_v_q} + {1'b0, skid_v_q}
                     + {1'b0, inflight_q};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({bus.wb_pc, bus.wb_dest, bus.wb_value}),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next-state: abort wins, arm only from IDLE
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (arm) state_d = ST_PRE;
                ST_PRE: begin
                    if (rec) begin
                        if (stop_full) begin
                            if (count_q == FULL - 1'b1) state_d = ST_DONE;
                        end else if (trig_hit) begin
                            state_d = (post_count == '0) ? ST_DONE
                                                         : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (rec && post_q == AW'(1)) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (count_q == '0 || (pop && count_q == (AW+1)'(1)))
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // datapath: recording, readout fetch and output staging
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fetch_d     = fetch_q;
        post_d      = post_q;
        overflow_d  = overflow_q;
        inflight_d  = 1'b0;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        if (abort) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_d    = '0;
            overflow_d = 1'b0;
            out_v_d    = 1'b0;
            out_data_d = '0;
            skid_v_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        count_d    = '0;
                        fetch_d    = '0;
                        overflow_d = 1'b0;
                    end
                end
                ST_PRE, ST_POST: begin
                    if (rec) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == FULL) overflow_d = 1'b1;
                        else                 count_d    = count_q + 1'b1;
                        post_d = (state_q == ST_PRE) ? post_count
                                                     : post_q - 1'b1;
                    end
                    // oldest entry sits count places behind the write pointer
                    if (state_d == ST_DONE) begin
                        rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                        fetch_d  = count_d;
                    end
                end
                ST_DONE: begin
                    // keep at most two entries staged or in flight
                    if (fetch_q != '0 && (occ - {1'b0, pop}) < 2'd2) begin
                        ram_re     = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        fetch_d    = fetch_q - 1'b1;
                        inflight_d = 1'b1;
                    end
                    if (pop) count_d = count_q - 1'b1;
                    if (!out_v_q || pop) begin
                        if (skid_v_q) begin
                            out_v_d     = 1'b1;
                            out_data_d  = skid_data_q;
                            skid_v_d    = inflight_q;
                            skid_data_d = ram_rdata;
                        end else if (inflight_q) begin
                            out_v_d    = 1'b1;
                            out_data_d = ram_rdata;
                        end else begin
                            out_v_d = 1'b0;
                        end
                    end else if (inflight_q) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fetch_q     <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            inflight_q  <= 1'b0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetch_q     <= fetch_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            inflight_q  <= inflight_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign state        = state_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign bus.rd_valid = out_v_q;
    assign bus.rd_data  = out_data_q;
    assign bus.rd_last  = out_v_q & (count_q == (AW+1)'(1));
endmodule
